uart_tx_ser: RTL and testbench

- 8N1 UART transmitter; the transmit counterpart of the board's 115200-baud receiver path. Clocked from the 27 MHz board clock.
- Accepts one byte per valid/ready handshake, serialises it LSB-first on uart_tx and signals completion.
- Sits between user logic (key handlers, loopback or echo logic) and the board's UART TX pin.

---
 rtl/uart_tx_ser_if.sv | 20 ++
 rtl/uart_tx_ser.sv | 154 +++++++++++++++
 tb/tb_uart_tx_ser.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ser_if.sv
// Byte-transmit interface between user logic and the 8N1 serialiser.
// A byte moves when tx_valid && tx_ready on a clk edge; tx_data only matters on that edge.
interface uart_tx_ser_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       uart_tx;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_busy, tx_done, uart_tx
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_busy, tx_done, uart_tx
  );
endinterface

// File: rtl/uart_tx_ser.sv
// 8N1 UART transmitter, LSB first, all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_ser #(
  parameter int BAUDRATE_CNT = 234
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_ser_if.slave     bus,
  output logic [2:0]       dbg_state_o
);

  localparam int BAUD_W = (BAUDRATE_CNT > 1) ? $clog2(BAUDRATE_CNT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUDRATE_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic baud_end;
  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (bus.tx_valid && ready_q) begin
          state_d = S_START;
          shreg_d = bus.tx_data;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = ^bus.tx_data;
`endif
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        // Unreachable encodings fall back to a clean idle line.
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.uart_tx  = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_uart_tx_ser.sv
// Self-checking bench for uart_tx_ser: a fast instance (4 cycles/bit) and a default-rate instance.
// Expected bytes are queued when driven and popped by the frame checker.
module tb_uart_tx_ser;
  localparam int BF = 4;
  localparam int BS = 234;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       v_valid = 1'b0;
  logic [7:0] v_data = 8'h00;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         last_start = 0;
  logic [7:0] exp_q[$];
  logic [2:0] f_dbg, s_dbg;

  uart_tx_ser_if f_if ();
  uart_tx_ser_if s_if ();

  assign f_if.tx_valid = v_valid & ~sel;
  assign f_if.tx_data  = v_data;
  assign s_if.tx_valid = v_valid & sel;
  assign s_if.tx_data  = v_data;

  uart_tx_ser #(.BAUDRATE_CNT(BF)) dut (
    .clk(clk), .rst(rst), .bus(f_if.slave), .dbg_state_o(f_dbg)
  );

  uart_tx_ser dut_slow (
    .clk(clk), .rst(rst), .bus(s_if.slave), .dbg_state_o(s_dbg)
  );

  wire mon_tx    = sel ? s_if.uart_tx  : f_if.uart_tx;
  wire mon_ready = sel ? s_if.tx_ready : f_if.tx_ready;
  wire mon_busy  = sel ? s_if.tx_busy  : f_if.tx_busy;
  wire mon_done  = sel ? s_if.tx_done  : f_if.tx_done;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_tx"},    mon_tx,    1'b1);
    check_eq({tag, "_ready"}, mon_ready, 1'b1);
    check_eq({tag, "_busy"},  mon_busy,  1'b0);
    check_eq({tag, "_done"},  mon_done,  1'b0);
  endtask

  // driver: one-cycle tx_valid pulse, optionally recording the byte as expected
  task automatic send_byte(input logic [7:0] d, input bit push);
    @(negedge clk);
    v_data  = d;
    v_valid = 1'b1;
    if (push) exp_q.push_back(d);
    @(negedge clk);
    v_valid = 1'b0;
  endtask

  // scoreboard consumer: waits for a start bit, then checks every cycle of the frame
  task automatic check_frame();
    logic [7:0]    d;
    logic [NB-1:0] bits;
    int            baud;
    bit            found;
    baud = sel ? BS : BF;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
      return;
    end
    d = exp_q.pop_front();
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    bits[9] = ^d;
`endif
    bits[NB-1] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < baud * 12 + 20; i++) begin
      if (mon_tx === 1'b0 && mon_busy === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("start_seen", found, 1'b1);
    if (!found) return;
    last_start = cyc;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < baud; c++) begin
        check_eq($sformatf("byte%02h_bit%0d", d, b), mon_tx, bits[b]);
        if (c == baud - 1) check_eq("done_early", mon_done, 1'b0);
        @(negedge clk);
      end
    end
    check_eq("frame_len", cyc - last_start, baud * NB);
    check_eq("done_pulse", mon_done,  1'b1);
    check_eq("ready_back", mon_ready, 1'b1);
    check_eq("busy_clear", mon_busy,  1'b0);
    check_eq("line_idle",  mon_tx,    1'b1);
    @(negedge clk);
    check_eq("done_one_cycle", mon_done, 1'b0);
  endtask

  initial begin
    int s1;
    int lows;
    int dones;

    // reset asserted between clock edges
    #1 rst = 1'b1;
    #1;
    check_idle_outputs("rst_async");
    check_eq("rst_state_fast", f_dbg, 3'd0);
    check_eq("rst_state_slow", s_dbg, 3'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_rst");

    // single byte 0x55
    send_byte(8'h55, 1'b1);
    check_frame();

    // back-to-back, tx_valid held high
    @(negedge clk);
    v_data  = 8'hA5;
    v_valid = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    fork
      begin
        check_frame();
        s1 = last_start;
        check_frame();
        check_eq("b2b_gap", last_start - s1, BF * NB + 1);
      end
      begin
        @(negedge clk);
        v_data = 8'h3C;
        repeat (BF * NB + 1) @(negedge clk);
        v_valid = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check_idle_outputs("b2b_after");

    // tx_valid during a frame is ignored
    fork
      begin
        send_byte(8'h0F, 1'b1);
        check_frame();
      end
      begin
        repeat (11) @(negedge clk);
        v_data  = 8'hFF;
        v_valid = 1'b1;
        @(negedge clk);
        v_valid = 1'b0;
      end
    join
    lows = 0;
    dones = 0;
    for (int i = 0; i < 3 * BF * NB; i++) begin
      if (mon_tx !== 1'b1) lows++;
      if (mon_done !== 1'b0) dones++;
      @(negedge clk);
    end
    check_eq("ignored_line", lows, 0);
    check_eq("ignored_done", dones, 0);
    check_eq("sb_drained", exp_q.size(), 0);

    // reset in the middle of data bit 3 of 0xAA
    send_byte(8'hAA, 1'b0);
    repeat (BF + 3 * BF + 1) @(negedge clk);
    check_eq("pre_abort_busy", mon_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("rst_midframe");
    @(negedge clk);
    check_idle_outputs("rst_held");
    rst = 1'b0;
    dones = 0;
    lows = 0;
    for (int i = 0; i < 2 * BF * NB; i++) begin
      if (mon_tx !== 1'b1) lows++;
      if (mon_done !== 1'b0) dones++;
      @(negedge clk);
    end
    check_eq("abort_no_resume", lows, 0);
    check_eq("abort_no_done", dones, 0);
    send_byte(8'h81, 1'b1);
    check_frame();

`ifdef UART_TX_PARITY_EN
    send_byte(8'h07, 1'b1);
    check_frame();
    send_byte(8'h03, 1'b1);
    check_frame();
`endif

    // default bit period on the second instance
    sel = 1'b1;
    @(negedge clk);
    check_idle_outputs("slow_idle");
    send_byte(8'h41, 1'b1);
    check_frame();
    sel = 1'b0;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
